// File: rtl/inv_adap_quan.sv
// inv_adap_quan: 32 kbit/s ADPCM inverse adaptive quantizer, codeword I + scale Y -> sign-magnitude DQ.
// IAQ_SERIAL_SHIFT_EN: replaces the one-cycle antilog barrel shift with a bit-serial SHIFT state.
module inv_adap_quan (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_in0,
    input  logic        scan_en,
    output logic        scan_out0,
    input  logic [3:0]  i_in,
    input  logic [12:0] y_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] dq_out,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [2:0] {IDLE, ADDA, ANTILOG, SHIFT, DONE} state_t;
    state_t      state;
    logic [3:0]  i_q;
    logic [10:0] y_q;
    logic [11:0] dql;
    logic [11:0] dqln;
    logic [2:0]  k;
    logic [3:0]  dex;
    logic [7:0]  dqt;
    logic        unused_ok;
    assign scan_out0 = 1'b0;
    assign dex = dql[10:7];
    assign dqt = {1'b1, dql[6:0]};
    // DQLN is symmetric about the sign bit, so fold I onto an 8-entry table
    assign k = i_q[3] ? ~i_q[2:0] : i_q[2:0];
    always_comb begin
        case (k)
            3'd0:    dqln = 12'd2048;
            3'd1:    dqln = 12'd4;
            3'd2:    dqln = 12'd135;
            3'd3:    dqln = 12'd213;
            3'd4:    dqln = 12'd273;
            3'd5:    dqln = 12'd323;
            3'd6:    dqln = 12'd373;
            default: dqln = 12'd425;
        endcase
    end
`ifdef IAQ_SERIAL_SHIFT_EN
    logic [14:0] sh;
    logic [14:0] sh_nx;
    logic [3:0]  cnt;
    assign unused_ok = &{scan_in0, scan_en, y_in[1:0]};
    // DEX=15 is the only left shift; everything else walks right toward >>14
    assign sh_nx = (dex == 4'd15) ? {sh[13:0], 1'b0} : {1'b0, sh[14:1]};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dq_out    <= '0;
            i_q       <= '0;
            y_q       <= '0;
            dql       <= '0;
            sh        <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    i_q      <= i_in;
                    y_q      <= y_in[12:2];
                    in_ready <= 1'b0;
                    state    <= ADDA;
                end
                ADDA: begin
                    dql   <= dqln + {1'b0, y_q};
                    state <= ANTILOG;
                end
                ANTILOG: if (dql[11] || dex == 4'd14) begin
                    dq_out    <= {i_q[3], dql[11] ? 15'd0 : {dqt, 7'd0}};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    sh    <= {dqt, 7'd0};
                    cnt   <= (dex == 4'd15) ? 4'd1 : 4'd14 - dex;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sh  <= sh_nx;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        dq_out    <= {i_q[3], sh_nx};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
`else
    logic [29:0] prod;
    logic [14:0] mag;
    assign prod = ((30'(dqt) << 7) << dex) >> 14;
    assign mag = dql[11] ? 15'd0 : prod[14:0];
    assign unused_ok = &{scan_in0, scan_en, y_in[1:0], prod[29:15]};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dq_out    <= '0;
            i_q       <= '0;
            y_q       <= '0;
            dql       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    i_q      <= i_in;
                    y_q      <= y_in[12:2];
                    in_ready <= 1'b0;
                    state    <= ADDA;
                end
                ADDA: begin
                    dql   <= dqln + {1'b0, y_q};
                    state <= ANTILOG;
                end
                ANTILOG: begin
                    dq_out    <= {i_q[3], mag};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
`endif
endmodule

// File: doc/inv_adap_quan.md
INV_ADAP_QUAN -- requirements
Module: inv_adap_quan

Interface
REQ-001 The block SHALL have one clock and one reset: the clock SHALL be named clk and the reset SHALL be named reset; reset SHALL be asynchronous and active-low.
REQ-002 The ports SHALL be, one per line:
 clk  in  1  system clock, rising edge
 reset  in  1  asynchronous active-low system reset
 scan_in0  in  1  test scan data input
 scan_en  in  1  test scan enable
 scan_out0  out  1  test scan data output; functional RTL SHALL drive 0
 i_in  in  4  ADPCM codeword I, 32 kbit/s, bit 3 = sign
 y_in  in  13  quantizer scale factor Y, unsigned, legal range 544..5120
 in_valid  in  1  i_in/y_in valid
 in_ready  out  1  block can accept
 dq_out  out  16  quantized difference DQ, sign-magnitude: bit 15 sign, bits 14:0 magnitude
 out_valid  out  1  dq_out valid
 out_ready  in  1  sink accepts dq_out

Function
REQ-003 Transfers SHALL occur on rising clk when valid and ready are both 1.
REQ-004 The FSM SHALL have states IDLE, ADDA, ANTILOG, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-005 In IDLE, an input transfer SHALL capture i_in and y_in and go to ADDA; otherwise stay in IDLE.
REQ-006 ADDA SHALL register DQL = (DQLN(i_in) + (y_in >> 2)) mod 4096, then go to ANTILOG.
REQ-007 DQLN SHALL be 12-bit: I=0:2048, 1:4, 2:135, 3:213, 4:273, 5:323, 6:373, 7:425, 8:425, 9:373, 10:323, 11:273, 12:213, 13:135, 14:4, 15:2048.
REQ-008 ANTILOG SHALL form DEX=DQL[10:7] and DQT=128+DQL[6:0].
REQ-009 The magnitude SHALL be DQMAG = 0 if DQL[11]=1, else bits 14:0 of ((DQT << 7) << DEX) >> 14, computed at 30-bit width.
REQ-010 dq_out SHALL be {i_in[3], DQMAG[14:0]}; the sign SHALL come from I even when DQMAG=0.
REQ-011 Without the configuration macro, ANTILOG SHALL compute DQMAG in one cycle and go to DONE: out_valid rises 3 clocks after the input transfer edge.
REQ-012 In DONE, dq_out SHALL hold stable while out_ready=0; an output transfer SHALL return the FSM to IDLE.
REQ-013 The block SHALL hold one operation at a time; in_valid outside IDLE SHALL be ignored, and no input SHALL be captured in the cycle of an output transfer.
REQ-014 Arithmetic SHALL be unsigned modular; no saturation is applied beyond REQ-009 truncation.

Reset
REQ-015 While reset=0, the FSM SHALL be in IDLE, and in_ready SHALL be 1; out_valid, dq_out, scan_out0 and all internal registers SHALL be 0.
REQ-016 Reset asserted mid-operation SHALL abort the operation; no output SHALL appear for it after release.
REQ-017 The first input transfer SHALL occur no earlier than the first rising clk after reset deasserts.

Configuration
REQ-018 When IAQ_SERIAL_SHIFT_EN is defined, SHIFT SHALL right-shift DQT<<7 by one bit per cycle for 14-DEX cycles, or 0 cycles when DEX>=14 (DEX=15 uses a single-cycle left shift by 1), then go to DONE.
REQ-019 With IAQ_SERIAL_SHIFT_EN, latency SHALL be 3+max(0,14-DEX) clocks; without it, SHIFT SHALL be unreachable. Results SHALL be identical in both builds.

Verification
REQ-020 i_in=0001, y_in=544 -> DQL=140, DEX=1 -> dq_out=0x0002; out_valid at +3 clocks (macro on: +16).
REQ-021 i_in=0111, y_in=5120 -> DQL=1705 -> dq_out=0x2A40; i_in=1000, y_in=5120 -> dq_out=0xAA40 (macro on: +4 clocks).
REQ-022 i_in=0000, y_in=544 -> DQL=2184 (bit 11 set) -> dq_out=0x0000; i_in=1111, same y_in -> dq_out=0x8000.
REQ-023 Result ready, out_ready=0 for 5 cycles, in_valid=1 with new data -> dq_out held, in_ready=0, new data not captured; out_ready=1 -> transfer, then IDLE captures the new data.
REQ-024 Reset pulsed low during ADDA or SHIFT -> out_valid=0, dq_out=0, in_ready=1 immediately; no stale output after release.
